// File: rtl/reg_writeback_queue_if.sv
// ----------------------------------------------------------------------------
// reg_writeback_queue_if
//   Bundles the result-producer handshake, the register-file write port and the
//   decode forwarding lookup of reg_writeback_queue.
//
//   Producer handshake : in_valid, in_ready, in_rd, in_data
//   Register-file port : wb_stall, writedata, rd, regwrite
//   Forwarding lookup  : rs1, rs2, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
//   Status             : count
//
//   slave  : the queue itself
//   master : everything around it (producer, register file, decode)
// ----------------------------------------------------------------------------
interface reg_writeback_queue_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_rd;
    logic [XLEN-1:0]  in_data;
    logic             wb_stall;
    logic [XLEN-1:0]  writedata;
    logic [4:0]       rd;
    logic             regwrite;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             fwd1_hit;
    logic [XLEN-1:0]  fwd1_data;
    logic             fwd2_hit;
    logic [XLEN-1:0]  fwd2_data;
    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, in_rd, in_data, wb_stall, rs1, rs2,
        output in_ready, writedata, rd, regwrite,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
    );

    modport master (
        output in_valid, in_rd, in_data, wb_stall, rs1, rs2,
        input  in_ready, writedata, rd, regwrite,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// ----------------------------------------------------------------------------
// reg_writeback_queue
//   Write-side producer for the integer register file. Completed results
//   {rd, value} are accepted over a valid/ready handshake, held in a small
//   in-order FIFO and retired one per cycle onto the register-file write port.
//   Decode can look up values that are still pending through two forwarding
//   queries.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous active-low reset
//     wbq    - reg_writeback_queue_if.slave
//                in_valid/in_ready/in_rd/in_data : result input handshake
//                wb_stall                        : write port busy this cycle
//                writedata/rd/regwrite           : register-file write port
//                rs1/rs2 -> fwdN_hit/fwdN_data   : forwarding lookup
//                count                           : pending entries
// ----------------------------------------------------------------------------
module reg_writeback_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_writeback_queue_if.slave   wbq
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage is deliberately left out of reset; occupancy is tracked
    // by the pointers and count alone.
    logic [4:0]       r_rd_mem   [DEPTH];
    logic [XLEN-1:0]  r_data_mem [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;

    // Youngest pending value for a register index; {hit, data}.
    // Entries are scanned oldest to youngest so the last match wins.
    function automatic logic [XLEN:0] fwd_lookup(input logic [4:0] rs);
        logic             hit;
        logic [XLEN-1:0]  data;
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (rs != 5'd0) && (r_rd_mem[idx] == rs)) begin
                hit  = 1'b1;
                data = r_data_mem[idx];
            end
        end
        return {hit, data};
    endfunction

    // A full queue refuses input even on a cycle where it is draining.
    assign wbq.in_ready = (r_count < CNT_W'(DEPTH));
    assign w_accept     = wbq.in_valid && wbq.in_ready;
    // Writes to x0 complete the handshake but are dropped.
    assign w_push       = w_accept && (wbq.in_rd != 5'd0);
    assign w_nonempty   = (r_count != '0);
    assign w_pop        = w_nonempty && !wbq.wb_stall;

    assign wbq.regwrite  = w_pop;
    assign wbq.rd        = w_nonempty ? r_rd_mem[r_head]   : 5'd0;
    assign wbq.writedata = w_nonempty ? r_data_mem[r_head] : '0;
    assign wbq.count     = r_count;

    always_comb begin
        {wbq.fwd1_hit, wbq.fwd1_data} = fwd_lookup(wbq.rs1);
        {wbq.fwd2_hit, wbq.fwd2_data} = fwd_lookup(wbq.rs2);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_tail]   <= wbq.in_rd;
            r_data_mem[r_tail] <= wbq.in_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// ----------------------------------------------------------------------------
// tb_reg_writeback_queue
//   Directed bench for reg_writeback_queue. Accepted results are pushed into
//   an expected-write queue; a monitor on the falling edge pops and compares
//   whenever the register-file write port is enabled.
// ----------------------------------------------------------------------------
module tb_reg_writeback_queue;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    wb_t  exp_q[$];
    int   max_count;

    reg_writeback_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    reg_writeback_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .wbq   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every register-file write must match the oldest
    // outstanding accepted result.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.count > max_count) max_count = int'(bus.count);
            if (bus.regwrite) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h expected no write",
                             bus.rd, bus.writedata);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    chk("wb_rd",   64'(bus.rd), 64'(e.rd));
                    chk("wb_data", bus.writedata, e.data);
                end
            end
        end
    end

    // Present one result and hold it until accepted (bounded).
    task automatic push(input logic [4:0] r, input logic [XLEN-1:0] d);
        int  n;
        wb_t e;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_rd    = r;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                chk("push_timeout", 64'(bus.in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        if (bus.in_ready && r != 5'd0) begin
            e.rd   = r;
            e.data = d;
            exp_q.push_back(e);
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (bus.count != '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(bus.count), 64'd0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        max_count    = 0;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_rd    = 5'd0;
        bus.in_data  = '0;
        bus.wb_stall = 1'b0;
        bus.rs1      = 5'd0;
        bus.rs2      = 5'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_count",     64'(bus.count), 64'd0);
        chk("rst_regwrite",  64'(bus.regwrite), 64'd0);
        chk("rst_rd",        64'(bus.rd), 64'd0);
        chk("rst_writedata", bus.writedata, 64'd0);
        chk("rst_fwd1_hit",  64'(bus.fwd1_hit), 64'd0);
        chk("rst_fwd2_data", bus.fwd2_data, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

        // Single result into an empty queue
        @(posedge clk); #1;
        push(5'd5, 64'hAAAA_0000_0000_0001);
        @(negedge clk);
        chk("t1_regwrite", 64'(bus.regwrite), 64'd1);
        chk("t1_count",    64'(bus.count), 64'd1);
        @(negedge clk);
        chk("t1_regwrite_off", 64'(bus.regwrite), 64'd0);
        chk("t1_count_off",    64'(bus.count), 64'd0);

        // Fill under stall, overflow attempt, then drain in order
        @(posedge clk); #1;
        bus.wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 64'(i * 'h11));
        @(negedge clk);
        chk("t2_count_full", 64'(bus.count), 64'd4);
        chk("t2_in_ready",   64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_rd    = 5'd9;
        bus.in_data  = 64'h99;
        repeat (3) @(negedge clk);
        chk("t2_no_accept", 64'(bus.count), 64'd4);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.wb_stall = 1'b0;
        @(negedge clk);
        chk("t2_ready_still_0", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("t2_count3",  64'(bus.count), 64'd3);
        chk("t2_ready_1", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("t2_count2", 64'(bus.count), 64'd2);
        @(negedge clk);
        chk("t2_count1", 64'(bus.count), 64'd1);
        @(negedge clk);
        chk("t2_count0", 64'(bus.count), 64'd0);

        // x0 filtering
        @(posedge clk); #1;
        push(5'd0, 64'hFF);
        @(negedge clk);
        chk("t3_count",    64'(bus.count), 64'd0);
        chk("t3_regwrite", 64'(bus.regwrite), 64'd0);
        @(negedge clk);
        chk("t3_regwrite2", 64'(bus.regwrite), 64'd0);

        // Forwarding with duplicate destinations
        @(posedge clk); #1;
        bus.wb_stall = 1'b1;
        push(5'd7, 64'h10);
        push(5'd7, 64'h20);
        bus.rs1 = 5'd7;
        bus.rs2 = 5'd0;
        @(negedge clk);
        chk("t4_fwd1_hit",  64'(bus.fwd1_hit), 64'd1);
        chk("t4_fwd1_data", bus.fwd1_data, 64'h20);
        chk("t4_fwd2_hit",  64'(bus.fwd2_hit), 64'd0);
        chk("t4_fwd2_data", bus.fwd2_data, 64'd0);
        bus.rs2 = 5'd3;
        #1;
        chk("t4_fwd2_miss", 64'(bus.fwd2_hit), 64'd0);
        @(posedge clk); #1;
        bus.wb_stall = 1'b0;
        @(negedge clk);
        chk("t4_fwd_during_write", bus.fwd1_data, 64'h20);
        @(negedge clk);
        chk("t4_fwd_head_only", bus.fwd1_data, 64'h20);
        wait_empty();
        chk("t4_fwd_empty", 64'(bus.fwd1_hit), 64'd0);
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;

        // Pointer wrap: three held under stall, then push+pop every cycle
        @(posedge clk); #1;
        max_count    = 0;
        bus.wb_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus.wb_stall = 1'b0;
            push(5'(i + 20), 64'h1000 + 64'(i * 'h101));
        end
        @(negedge clk);
        chk("t5_count_steady", 64'(bus.count), 64'd3);
        wait_empty();
        chk("t5_max_count", 64'(max_count), 64'd3);

        // Asynchronous reset with entries pending
        @(posedge clk); #1;
        bus.wb_stall = 1'b1;
        push(5'd10, 64'hA0);
        push(5'd11, 64'hB0);
        push(5'd12, 64'hC0);
        bus.rs1 = 5'd11;
        @(negedge clk);
        chk("t6_count3",   64'(bus.count), 64'd3);
        chk("t6_fwd1_hit", 64'(bus.fwd1_hit), 64'd1);
        #2;
        bus.wb_stall = 1'b0;
        #1;
        chk("t6_regwrite_pre", 64'(bus.regwrite), 64'd1);
        exp_q.delete();
        reset = 1'b0;
        #1;
        chk("t6_regwrite_rst", 64'(bus.regwrite), 64'd0);
        chk("t6_count_rst",    64'(bus.count), 64'd0);
        chk("t6_fwd1_rst",     64'(bus.fwd1_hit), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.rs1 = 5'd0;
        @(negedge clk);
        chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (5) @(negedge clk);
        chk("t6_no_stale", 64'(bus.count), 64'd0);
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
